adc_stage_code_gen: RTL

ADC_STAGE_CODE_GEN -- requirements
Module: adc_stage_code_gen

---
 rtl/adc_stage_code_gen_if.sv | 28 ++
 rtl/adc_stage_code_gen.sv | 104 ++++++++++
 2 files changed

// File: rtl/adc_stage_code_gen_if.sv
// adc_stage_code_gen_if: word/sweep request inputs and stage thermometer outputs of adc_stage_code_gen
// Signals: in_code/in_valid/in_ready word handshake; sweep_start/sweep_lo/sweep_hi sweep request;
//   t1..t5 stage thermometer codes; word_last end-of-word pulse; busy; oor_err sticky range flag.
// master = stimulus side, slave = the code generator.
interface adc_stage_code_gen_if;
  logic [12:0] in_code;
  logic in_valid;
  logic in_ready;
  logic sweep_start;
  logic [12:0] sweep_lo;
  logic [12:0] sweep_hi;
  logic [13:0] t1;
  logic [5:0] t2;
  logic [5:0] t3;
  logic [5:0] t4;
  logic [14:0] t5;
  logic word_last;
  logic busy;
  logic oor_err;
  modport master (
    output in_code, in_valid, sweep_start, sweep_lo, sweep_hi,
    input in_ready, t1, t2, t3, t4, t5, word_last, busy, oor_err
  );
  modport slave (
    input in_code, in_valid, sweep_start, sweep_lo, sweep_hi,
    output in_ready, t1, t2, t3, t4, t5, word_last, busy, oor_err
  );
endinterface

// File: rtl/adc_stage_code_gen.sv
// adc_stage_code_gen: splits a 13-bit code into five skewed stage thermometer codes, with optional code sweep
// Ports: clk_p1_delay clock; rst synchronous active-high reset;
//   bus (adc_stage_code_gen_if.slave): in_code/in_valid/in_ready word input, sweep_start/sweep_lo/sweep_hi
//   sweep request, t1(14b) t2/t3/t4(6b) t5(15b) stage codes, word_last, busy, oor_err.
// Build option: define CODE_SWEEP_EN to include the SWEEP/DRAIN sweep generator; otherwise the
//   sweep inputs are ignored and the block only converts handshaken words.
module adc_stage_code_gen #(
  parameter logic [12:0] SWEEP_STEP = 13'd1
) (
  input logic clk_p1_delay,
  input logic rst,
  adc_stage_code_gen_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;
  state_t r_state, w_next;
  logic [5:0] r_v;
  logic [12:0] r_c0;
  logic [8:0] r_c1;
  logic [6:0] r_c2;
  logic [4:0] r_c3;
  logic [2:0] r_c4;
  logic [13:0] r_t1;
  logic [5:0] r_t2, r_t3, r_t4;
  logic [14:0] r_t5;
  logic r_oor;
  logic w_inj, w_oor, w_ready;
  logic [12:0] w_raw, w_sat;
  function automatic logic [14:0] therm(input logic [3:0] n);
    return 15'((32'd1 << n) - 32'd1);
  endfunction
  always_ff @(posedge clk_p1_delay)
    r_state <= rst ? IDLE : w_next;
`ifdef CODE_SWEEP_EN
  logic [12:0] r_cur, r_hi;
  logic [13:0] w_step;
  logic w_more;
  // one extra bit catches 13-bit overflow of the running sweep code
  assign w_step = {1'b0, r_cur} + {1'b0, SWEEP_STEP};
  assign w_more = ~w_step[13] & (w_step[12:0] <= r_hi);
  always_comb
    w_next = r_state == IDLE ? (bus.sweep_start ? SWEEP : IDLE) :
             r_state == SWEEP ? (w_more ? SWEEP : DRAIN) :
             (|r_v ? DRAIN : IDLE);
  always_ff @(posedge clk_p1_delay)
    if (r_state == IDLE && bus.sweep_start) begin
      r_cur <= bus.sweep_lo;
      r_hi <= bus.sweep_hi;
    end else if (r_state == SWEEP && w_more) r_cur <= w_step[12:0];
`else
  logic w_unused;
  assign w_unused = ^{bus.sweep_start, bus.sweep_lo, bus.sweep_hi, SWEEP_STEP};
  assign w_next = IDLE;
`endif
  always_comb begin
`ifdef CODE_SWEEP_EN
    w_ready = r_state == IDLE & ~bus.sweep_start & ~rst;
    w_raw = r_state == SWEEP ? r_cur : bus.in_code;
    w_inj = r_state == SWEEP | (bus.in_valid & w_ready);
`else
    w_ready = ~rst;
    w_raw = bus.in_code;
    w_inj = bus.in_valid & w_ready;
`endif
    w_oor = w_raw[12:9] > 4'd13;
    w_sat = w_oor ? 13'h1BFF : w_raw;
  end
  // r_v[0] marks the captured word, r_v[k] the stage whose t_k just loaded; r_v[5] is word_last
  always_ff @(posedge clk_p1_delay) begin
    if (rst) begin
      r_v <= '0;
      r_t1 <= '0;
      r_t2 <= '0;
      r_t3 <= '0;
      r_t4 <= '0;
      r_t5 <= '0;
      r_oor <= 1'b0;
    end else begin
      r_v <= {r_v[4:0], w_inj};
      r_oor <= r_oor | (w_inj & w_oor);
      if (r_v[0]) r_t1 <= 14'(therm(r_c0[12:9]));
      if (r_v[1]) r_t2 <= 6'(therm({2'b0, r_c1[8:7]}));
      if (r_v[2]) r_t3 <= 6'(therm({2'b0, r_c2[6:5]}));
      if (r_v[3]) r_t4 <= 6'(therm({2'b0, r_c3[4:3]}));
      if (r_v[4]) r_t5 <= therm({1'b0, r_c4[2:0]});
    end
  end
  // each stage forwards only the fields still to be decoded downstream
  always_ff @(posedge clk_p1_delay) begin
    if (w_inj) r_c0 <= w_sat;
    r_c1 <= r_c0[8:0];
    r_c2 <= r_c1[6:0];
    r_c3 <= r_c2[4:0];
    r_c4 <= r_c3[2:0];
  end
  assign bus.in_ready = w_ready;
  assign bus.t1 = r_t1;
  assign bus.t2 = r_t2;
  assign bus.t3 = r_t3;
  assign bus.t4 = r_t4;
  assign bus.t5 = r_t5;
  assign bus.word_last = r_v[5];
  assign bus.busy = (r_state != IDLE) | (|r_v);
  assign bus.oor_err = r_oor;
endmodule
